// File: rtl/niu_rx_mac_filter.sv
// RX destination-MAC filter: NUM_MAC programmable entries, frame-atomic pass/drop, saturating counters.
// Build option: define NIU_RX_BCAST_PASS_EN to treat the broadcast DA as an unconditional hit.
module niu_rx_mac_filter #(
  parameter int unsigned NUM_MAC = 4,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk156,
  input  logic             aresetn,
  input  logic             filter_en,
  input  logic             mac_wr,
  input  logic [IDX_W-1:0] mac_wr_idx,
  input  logic             mac_wr_vld,
  input  logic [47:0]      mac_wr_addr,
  input  logic [63:0]      s_axis_tdata,
  input  logic [7:0]       s_axis_tkeep,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tuser,
  output logic             s_axis_tready,
  output logic [63:0]      m_axis_tdata,
  output logic [7:0]       m_axis_tkeep,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  input  logic             m_axis_tready,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int unsigned DATA_W    = 64;
  localparam int unsigned KEEP_W    = 8;
  localparam int unsigned MAC_W     = 48;
  localparam int unsigned MAC_BYTES = 6;

  typedef struct packed {
    logic              user;
    logic              last;
    logic [KEEP_W-1:0] keep;
    logic [DATA_W-1:0] data;
  } beat_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  beat_t              beat_q, beat_d;
  beat_t              s_beat;
  logic               out_vld_q, out_vld_d;
  logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [MAC_W-1:0]   tbl_addr_q [NUM_MAC];
  logic [MAC_W-1:0]   tbl_addr_d [NUM_MAC];
  logic [NUM_MAC-1:0] tbl_vld_q, tbl_vld_d;

  logic tbl_hit;
  logic bcast;
  logic hit;
  logic accept;
  logic fwd;
  logic pass_done;
  logic drop_done;

  // Table address is stored MSB-first; the wire carries DA byte 0 in tdata[7:0].
  function automatic logic [MAC_W-1:0] wire_order(input logic [MAC_W-1:0] a);
    logic [MAC_W-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < MAC_BYTES; b++) begin
      r[8*b +: 8] = a[MAC_W-1-8*b -: 8];
    end
    return r;
  endfunction

  assign s_beat = {s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata};

  // Table write port; out-of-range indices match no entry and are dropped.
  always_comb begin
    tbl_addr_d = tbl_addr_q;
    tbl_vld_d  = tbl_vld_q;
    for (int unsigned i = 0; i < NUM_MAC; i++) begin
      if (mac_wr && (mac_wr_idx == IDX_W'(i))) begin
        tbl_addr_d[i] = mac_wr_addr;
        tbl_vld_d[i]  = mac_wr_vld;
      end
    end
  end

  // Lookup uses registered table contents, so a same-cycle write is not seen.
  always_comb begin
    tbl_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_MAC; i++) begin
      if (tbl_vld_q[i] && (s_axis_tdata[MAC_W-1:0] == wire_order(tbl_addr_q[i]))) begin
        tbl_hit = 1'b1;
      end
    end
  end

`ifdef NIU_RX_BCAST_PASS_EN
  assign bcast = &s_axis_tdata[MAC_W-1:0];
`else
  assign bcast = 1'b0;
`endif

  assign hit = ~filter_en | tbl_hit | bcast;

  // Frame FSM, output slice and counter next-state.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    out_vld_d  = out_vld_q;
    pass_cnt_d = pass_cnt_q;
    drop_cnt_d = drop_cnt_q;
    fwd        = 1'b0;
    pass_done  = 1'b0;
    drop_done  = 1'b0;

    s_axis_tready = (state_q == ST_DROP) ? 1'b1 : (~out_vld_q | m_axis_tready);
    accept        = s_axis_tvalid & s_axis_tready;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (hit) begin
            fwd = 1'b1;
            if (s_axis_tlast) pass_done = 1'b1;
            else              state_d   = ST_PASS;
          end else begin
            if (s_axis_tlast) drop_done = 1'b1;
            else              state_d   = ST_DROP;
          end
        end
      end
      ST_PASS: begin
        if (accept) begin
          fwd = 1'b1;
          if (s_axis_tlast) begin
            pass_done = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (accept && s_axis_tlast) begin
          drop_done = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fwd) begin
      beat_d    = s_beat;
      out_vld_d = 1'b1;
    end else if (m_axis_tready) begin
      out_vld_d = 1'b0;
    end

    if (pass_done && !(&pass_cnt_q)) pass_cnt_d = pass_cnt_q + CNT_W'(1);
    if (drop_done && !(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      out_vld_q  <= 1'b0;
      pass_cnt_q <= '0;
      drop_cnt_q <= '0;
      tbl_vld_q  <= '0;
      for (int unsigned i = 0; i < NUM_MAC; i++) begin
        tbl_addr_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      out_vld_q  <= out_vld_d;
      pass_cnt_q <= pass_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      tbl_vld_q  <= tbl_vld_d;
      tbl_addr_q <= tbl_addr_d;
    end
  end

  assign m_axis_tdata  = beat_q.data;
  assign m_axis_tkeep  = beat_q.keep;
  assign m_axis_tlast  = beat_q.last;
  assign m_axis_tuser  = beat_q.user;
  assign m_axis_tvalid = out_vld_q;
  assign pass_cnt      = pass_cnt_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_niu_rx_mac_filter.sv
// Randomized bench for niu_rx_mac_filter against a frame-level model (table, hit rule, saturating counts).
module tb_niu_rx_mac_filter;

  localparam int unsigned NUM_MAC = 3;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CMAX    = (1 << CNT_W) - 1;
  localparam logic [47:0] BCAST   = 48'hffff_ffff_ffff;

  logic             clk156 = 1'b0;
  logic             aresetn;
  logic             filter_en;
  logic             mac_wr;
  logic [IDX_W-1:0] mac_wr_idx;
  logic             mac_wr_vld;
  logic [47:0]      mac_wr_addr;
  logic [63:0]      s_axis_tdata;
  logic [7:0]       s_axis_tkeep;
  logic             s_axis_tvalid;
  logic             s_axis_tlast;
  logic             s_axis_tuser;
  logic             s_axis_tready;
  logic [63:0]      m_axis_tdata;
  logic [7:0]       m_axis_tkeep;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic             m_axis_tuser;
  logic             m_axis_tready;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] drop_cnt;

  niu_rx_mac_filter #(.NUM_MAC(NUM_MAC), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk156(clk156), .aresetn(aresetn), .filter_en(filter_en),
    .mac_wr(mac_wr), .mac_wr_idx(mac_wr_idx), .mac_wr_vld(mac_wr_vld), .mac_wr_addr(mac_wr_addr),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .pass_cnt(pass_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk156 = ~clk156;

  // Reference model state
  logic [47:0]  m_addr [NUM_MAC];
  bit           m_vld  [NUM_MAC];
  int unsigned  m_pass, m_drop;
  logic [73:0]  exp_q [$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           rdy_mode = 0;
  bit           mon_en = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_hit(input logic [47:0] da, input bit fen);
    bit h;
    h = !fen;
`ifdef NIU_RX_BCAST_PASS_EN
    if (da == BCAST) h = 1'b1;
`endif
    for (int i = 0; i < int'(NUM_MAC); i++) if (m_vld[i] && m_addr[i] == da) h = 1'b1;
    return h;
  endfunction

  function automatic void model_wr(input logic [IDX_W-1:0] idx, input bit v, input logic [47:0] a);
    int ii;
    ii = int'(idx);
    if (ii < int'(NUM_MAC)) begin
      m_addr[ii] = a;
      m_vld[ii]  = v;
    end
  endfunction

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Sink ready pattern: 0 = always ready, 1 = random, 2 = toggling
  always @(posedge clk156) begin
    #1;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = ~m_axis_tready;
    endcase
  end

  // Output monitor: in-order beat check plus hold-stability while stalled.
  logic [73:0] held;
  bit          held_v = 1'b0;
  always @(negedge clk156) begin
    if (!aresetn || !mon_en) begin
      held_v = 1'b0;
    end else begin
      if (held_v)
        check("hold", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, {1'b1, held});
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) check("extra_beat", m_axis_tdata, 0);
        else check("beat", {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, exp_q.pop_front());
      end
      held_v = m_axis_tvalid && !m_axis_tready;
      held   = {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic wr_entry(input logic [IDX_W-1:0] idx, input bit v, input logic [47:0] a);
    mac_wr = 1'b1; mac_wr_idx = idx; mac_wr_vld = v; mac_wr_addr = a;
    @(posedge clk156); #1;
    mac_wr = 1'b0;
    model_wr(idx, v, a);
  endtask

  task automatic put_beat(input logic [63:0] d, input logic [7:0] k, input bit l, input bit u,
                          input bit gaps, input bit do_wr, input logic [IDX_W-1:0] wi,
                          input bit wv, input logic [47:0] wa, output bit ok, output int waitc);
    if (gaps && $urandom_range(0, 3) == 0) begin
      s_axis_tvalid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk156);
      #1;
    end
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tuser = u;
    s_axis_tvalid = 1'b1;
    waitc = 0; ok = 1'b0;
    while (!ok && waitc < 200) begin
      @(negedge clk156);
      if (s_axis_tready) ok = 1'b1;
      else waitc++;
    end
    if (!ok) begin
      check("accept_timeout", 0, 1);
      return;
    end
    if (do_wr) begin
      mac_wr = 1'b1; mac_wr_idx = wi; mac_wr_vld = wv; mac_wr_addr = wa;
    end
    @(posedge clk156); #1;
    mac_wr = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] da, input int nb, input bit fen, input bit gaps,
                            input int wr_beat, input logic [IDX_W-1:0] wi, input bit wv,
                            input logic [47:0] wa, input bit nobub);
    bit hit, ok, l, u;
    int w;
    logic [63:0] d;
    logic [7:0] k;
    hit = 1'b0;
    filter_en = fen;
    for (int b = 0; b < nb; b++) begin
      d = {$urandom, $urandom};
      if (b == 0) begin
        for (int j = 0; j < 6; j++) d[8*j +: 8] = da[47-8*j -: 8];
        hit = model_hit(da, fen);
      end
      l = (b == nb - 1);
      k = l ? 8'($urandom_range(1, 255)) : 8'hff;
      u = l ? 1'($urandom_range(0, 1)) : 1'b0;
      put_beat(d, k, l, u, gaps, b == wr_beat, wi, wv, wa, ok, w);
      if (!ok) begin
        s_axis_tvalid = 1'b0;
        return;
      end
      if (nobub) check("bubble", w, 0);
      if (hit) begin
        exp_q.push_back({u, l, k, d});
        check("lat_vld", m_axis_tvalid, 1);
        check("lat_data", m_axis_tdata, d);
      end
      if (b == wr_beat) model_wr(wi, wv, wa);
      if (b == 0) filter_en = 1'($urandom_range(0, 1));
    end
    s_axis_tvalid = 1'b0;
    if (hit) m_pass = sat_inc(m_pass);
    else     m_drop = sat_inc(m_drop);
    check("pass_cnt_frame", pass_cnt, m_pass);
    check("drop_cnt_frame", drop_cnt, m_drop);
  endtask

  task automatic settle(input string tag);
    rdy_mode = 0;
    repeat (6) @(posedge clk156);
    #1;
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_pass"}, pass_cnt, m_pass);
    check({tag, "_drop"}, drop_cnt, m_drop);
  endtask

  task automatic do_reset();
    #2 aresetn = 1'b0;
    s_axis_tvalid = 1'b0; mac_wr = 1'b0;
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tkeep", m_axis_tkeep, 0);
    check("rst_tlast_tuser", {m_axis_tlast, m_axis_tuser}, 0);
    check("rst_pass", pass_cnt, 0);
    check("rst_drop", drop_cnt, 0);
    exp_q.delete();
    m_pass = 0; m_drop = 0;
    for (int i = 0; i < int'(NUM_MAC); i++) begin m_addr[i] = '0; m_vld[i] = 1'b0; end
    repeat (2) @(posedge clk156);
    @(negedge clk156) aresetn = 1'b1;
    @(posedge clk156); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] da, wa, mac_a;
    bit ok;
    int w, nb, wb;
    aresetn = 1'b1; filter_en = 1'b0; mac_wr = 1'b0; mac_wr_idx = '0; mac_wr_vld = 1'b0;
    mac_wr_addr = '0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0; s_axis_tuser = 1'b0; m_axis_tready = 1'b1;

    // T1: promiscuous pass with 1-cycle latency and no bubbles
    do_reset();
    mon_en = 1'b1;
    send_frame(48'h00_11_22_33_44_55, 3, 1'b0, 1'b0, -1, '0, 1'b0, '0, 1'b1);
    settle("t1");
    check("t1_pass_one", pass_cnt, 1);

    // T2: enabled entry hit vs. miss on neighbouring DA
    wr_entry(2'd2, 1'b1, 48'h00_0a_35_00_00_01);
    send_frame(48'h00_0a_35_00_00_01, 2, 1'b1, 1'b0, -1, '0, 1'b0, '0, 1'b1);
    send_frame(48'h00_0a_35_00_00_02, 2, 1'b1, 1'b0, -1, '0, 1'b0, '0, 1'b1);
    settle("t2");

    // T3: toggling sink ready, 8-beat and single-beat passed frames
    rdy_mode = 2;
    send_frame(48'h00_0a_35_00_00_01, 8, 1'b1, 1'b0, -1, '0, 1'b0, '0, 1'b0);
    send_frame(48'h00_0a_35_00_00_01, 1, 1'b1, 1'b0, -1, '0, 1'b0, '0, 1'b0);
    settle("t3");

    // T4: disabling the entry mid-frame, then in the SOF-accept cycle
    send_frame(48'h00_0a_35_00_00_01, 4, 1'b1, 1'b0, 2, 2'd2, 1'b0, 48'h00_0a_35_00_00_01, 1'b0);
    send_frame(48'h00_0a_35_00_00_01, 2, 1'b1, 1'b0, -1, '0, 1'b0, '0, 1'b0);
    wr_entry(2'd2, 1'b1, 48'h00_0a_35_00_00_01);
    send_frame(48'h00_0a_35_00_00_01, 1, 1'b1, 1'b0, 0, 2'd2, 1'b0, 48'h00_0a_35_00_00_01, 1'b0);
    send_frame(48'h00_0a_35_00_00_01, 1, 1'b1, 1'b0, -1, '0, 1'b0, '0, 1'b0);
    settle("t4");

    // T5: broadcast with empty table, and an out-of-range write
    do_reset();
    send_frame(BCAST, 2, 1'b1, 1'b0, -1, '0, 1'b0, '0, 1'b0);
    wr_entry(2'd3, 1'b1, 48'h02_de_ad_be_ef_01);
    send_frame(48'h02_de_ad_be_ef_01, 2, 1'b1, 1'b0, -1, '0, 1'b0, '0, 1'b0);
    settle("t5");
`ifdef NIU_RX_BCAST_PASS_EN
    check("t5_bcast_pass", pass_cnt, 1);
`else
    check("t5_bcast_drop", drop_cnt, 2);
`endif

    // Randomized traffic: mixed DAs, lengths, filter_en, mid-frame writes, random sink stalls
    for (int i = 0; i < int'(NUM_MAC); i++) wr_entry(2'(i), 1'($urandom_range(0, 1)), {$urandom, 16'($urandom)});
    rdy_mode = 1;
    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: da = m_addr[$urandom_range(0, NUM_MAC - 1)];
        3:       da = BCAST;
        default: da = {$urandom, 16'($urandom)};
      endcase
      nb = $urandom_range(1, 6);
      wb = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nb - 1) : -1;
      wa = ($urandom_range(0, 1) == 1) ? da : {$urandom, 16'($urandom)};
      send_frame(da, nb, 1'($urandom_range(0, 3) != 0), 1'b1, wb, 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), wa, 1'b0);
    end
    settle("rand");

    // T6: drop counter saturation, then reset in the middle of a passing frame
    do_reset();
    for (int f = 0; f < 17; f++)
      send_frame(48'h02_00_00_00_00_99, 1 + (f % 3), 1'b1, 1'b0, -1, '0, 1'b0, '0, 1'b0);
    settle("t6");
    check("t6_drop_sat", drop_cnt, 15);
    mac_a = 48'h02_aa_bb_cc_dd_ee;
    wr_entry(2'd0, 1'b1, mac_a);
    mon_en = 1'b0;
    put_beat({16'h1234, mac_a[7:0], mac_a[15:8], mac_a[23:16], mac_a[31:24], mac_a[39:32], mac_a[47:40]},
             8'hff, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, ok, w);
    put_beat({$urandom, $urandom}, 8'hff, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, ok, w);
    check("t6_mid_vld", m_axis_tvalid, 1);
    do_reset();
    mon_en = 1'b1;
    send_frame(mac_a, 3, 1'b1, 1'b0, -1, '0, 1'b0, '0, 1'b1);
    send_frame(mac_a, 2, 1'b0, 1'b0, -1, '0, 1'b0, '0, 1'b1);
    settle("t6_restart");
    check("t6_restart_counts", {pass_cnt, drop_cnt}, {4'd1, 4'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
